// File: rtl/sdram_frame_fetch.sv
// ---------------------------------------------------------------------------
// sdram_frame_fetch
//   Avalon-MM pipelined read master for the SDRAM controller s1 port.
//   Fetches word_count consecutive words from base_addr, buffers the returned
//   data in a show-ahead FIFO and streams it out on a valid/ready interface.
//   Reads are only issued while (reads in flight + words buffered) is below
//   FIFO_DEPTH, so every returned word always has a free FIFO slot.
// ---------------------------------------------------------------------------
module sdram_frame_fetch #(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 16,
   parameter int CNT_W      = 24,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   // control
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   // Avalon-MM master towards s1
   output logic [ADDR_W-1:0] avm_address,
   output logic [1:0]        avm_byteenable_n,
   output logic              avm_chipselect,
   output logic              avm_read_n,
   output logic              avm_write_n,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   input  logic              avm_waitrequest,
   // output stream
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int USED_W = PTR_W + 1;   // holds 0..FIFO_DEPTH
   localparam int CRD_W  = PTR_W + 2;   // holds pending + used without overflow

   localparam logic [USED_W-1:0] DEPTH_U = USED_W'(FIFO_DEPTH);
   localparam logic [CRD_W-1:0]  DEPTH_C = CRD_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;

   // transfer bookkeeping
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]  received_q, received_d;
   logic [USED_W-1:0] pending_q, pending_d;

   // output FIFO
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [USED_W-1:0] used_q, used_d;

   // handshake strobes
   logic             read_en;
   logic             accept;
   logic             push;
   logic             pop;
   logic             start_ok;
   logic             credit_ok;
   logic             last_accept;
   logic             drained;
   logic [CRD_W-1:0] credit_sum;

   // -------------------------------------------------------------------------
   // Strobe decode
   // -------------------------------------------------------------------------
   assign start_ok    = start && (state_q == S_IDLE);
   assign credit_sum  = CRD_W'(pending_q) + CRD_W'(used_q);
   assign credit_ok   = (credit_sum < DEPTH_C);
   assign accept      = read_en && !avm_waitrequest;
   assign last_accept = accept && ((issued_q + CNT_W'(1)) == count_q);
   // Data returning while idle belongs to a transfer that a reset aborted.
   assign push        = avm_readdatavalid && (state_q != S_IDLE);
   assign pop         = out_valid && out_ready;
   assign drained     = (received_q == count_q) && (used_q == '0);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples its pre-edge value regardless of block evaluation order.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   // NOTE: the default assignment at the top keeps every path assigned,
   // so no latch is inferred for state_d.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (word_count != '0) ? S_ISSUE : S_DONE;
            end
         end
         S_ISSUE: begin
            if (last_accept) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drained) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs decoded from the registered state
   // -------------------------------------------------------------------------
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      read_en = 1'b0;
      unique case (state_q)
         S_IDLE: begin
         end
         S_ISSUE: begin
            busy    = 1'b1;
            // Depends only on registered counters, so the request stays
            // stable for as long as waitrequest holds it off.
            read_en = (issued_q < count_q) && credit_ok;
         end
         S_DRAIN: begin
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath next-state: address, counters and FIFO pointers
   // -------------------------------------------------------------------------
   always_comb begin
      addr_d     = addr_q;
      count_d    = count_q;
      issued_d   = issued_q;
      received_d = received_q;
      pending_d  = pending_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      used_d     = used_q;

      if (start_ok) begin
         addr_d     = base_addr;
         count_d    = word_count;
         issued_d   = '0;
         received_d = '0;
      end else begin
         if (accept) begin
            // Natural modulo 2^ADDR_W wrap at the top of the address space.
            addr_d   = addr_q + ADDR_W'(1);
            issued_d = issued_q + CNT_W'(1);
         end
         if (push) begin
            received_d = received_q + CNT_W'(1);
         end
      end

      unique case ({accept, push})
         2'b10:   pending_d = pending_q + USED_W'(1);
         2'b01:   pending_d = pending_q - USED_W'(1);
         default: pending_d = pending_q;
      endcase

      unique case ({push, pop})
         2'b10:   used_d = used_q + USED_W'(1);
         2'b01:   used_d = used_q - USED_W'(1);
         default: used_d = used_q;
      endcase

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Datapath registers with synchronous reset
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         addr_q     <= '0;
         count_q    <= '0;
         issued_q   <= '0;
         received_q <= '0;
         pending_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         used_q     <= '0;
      end else begin
         addr_q     <= addr_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         received_q <= received_d;
         pending_q  <= pending_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         used_q     <= used_d;
      end
   end

   // -------------------------------------------------------------------------
   // FIFO storage write port
   // -------------------------------------------------------------------------
   // NOTE: the storage array has no reset; clearing the pointers and the
   // fill count empties the FIFO, and stale contents are never visible.
   always_ff @(posedge clk_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= avm_readdata;
      end
   end

   // The credit rule must make a push into a full FIFO impossible.
   assert property (@(posedge clk_clk) disable iff (reset_reset)
                    !(push && (used_q == DEPTH_U)));

   // -------------------------------------------------------------------------
   // Port assignments
   // -------------------------------------------------------------------------
   assign avm_address      = addr_q;
   assign avm_read_n       = !read_en;
   assign avm_chipselect   = read_en;
   assign avm_byteenable_n = 2'b00;
   assign avm_write_n      = 1'b1;
   assign avm_writedata    = '0;

   assign out_valid = (used_q != '0);
   assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sdram_frame_fetch.sv
// ---------------------------------------------------------------------------
// tb_sdram_frame_fetch
//   Self-checking bench: a behavioural s1 slave (in-order, variable latency,
//   optional waitrequest) and a scoreboard of expected read addresses and
//   output words computed directly from base_addr + i.
// ---------------------------------------------------------------------------
module tb_sdram_frame_fetch;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 24;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              reset_reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] avm_address;
   logic [1:0]        avm_byteenable_n;
   logic              avm_chipselect;
   logic              avm_read_n;
   logic              avm_write_n;
   logic [DATA_W-1:0] avm_writedata;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   always #5 clk = ~clk;

   sdram_frame_fetch #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_clk          (clk),
      .reset_reset      (reset_reset),
      .start            (start),
      .base_addr        (base_addr),
      .word_count       (word_count),
      .busy             (busy),
      .done             (done),
      .avm_address      (avm_address),
      .avm_byteenable_n (avm_byteenable_n),
      .avm_chipselect   (avm_chipselect),
      .avm_read_n       (avm_read_n),
      .avm_write_n      (avm_write_n),
      .avm_writedata    (avm_writedata),
      .avm_readdata     (avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest  (avm_waitrequest),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready)
   );

   // ---------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got transaction with value 0x%0h, required none", name, act);
   endtask

   // Contents of the simulated SDRAM: a fixed function of the word address.
   function automatic logic [15:0] mem_word(input logic [24:0] a);
      return a[15:0] ^ {a[24:16], 7'h2D} ^ 16'h5A5A;
   endfunction

   typedef struct {
      logic [15:0] data;
      int          due;
   } ret_t;

   ret_t        pipe[$];       // reads accepted by the slave, awaiting return
   logic [24:0] exp_addr[$];   // addresses the master must still request
   logic [15:0] exp_data[$];   // words the stream must still deliver

   int cyc          = 0;
   int lat_min      = 1;
   int lat_max      = 1;
   int wait_pct     = 0;
   int rdy_mode     = 0;       // 0: ready=1, 1: ready=0, 2: random
   int stall_idx    = -1;
   int stall_left   = 0;
   int stall_seen   = 0;
   bit stall_active = 1'b0;
   bit force_wait   = 1'b0;
   int xfer_acc     = 0;
   int first_acc    = 0;
   int last_acc     = 0;
   bit any_read     = 1'b0;
   int done_cnt     = 0;
   bit hold_prev    = 1'b0;
   logic [15:0] prev_data = '0;

   // ---------------------------------------------------------------------
   // s1 slave model: drives just after the edge, samples at the negedge
   // ---------------------------------------------------------------------
   initial begin
      ret_t r;
      int   lat;
      logic [24:0] ea;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      out_ready         = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         stall_active = 1'b0;
         if (force_wait) begin
            avm_waitrequest = 1'b1;
         end else if (!avm_read_n && xfer_acc == stall_idx && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
            stall_active = 1'b1;
         end else begin
            avm_waitrequest = ($urandom_range(0, 99) < wait_pct);
         end
         if (pipe.size() > 0 && pipe[0].due <= cyc) begin
            r = pipe.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = r.data;
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 16'($urandom);
         end
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 1) == 1);
         endcase

         @(negedge clk);
         check("chipselect_vs_read_n", avm_chipselect, !avm_read_n);
         if (!avm_read_n) any_read = 1'b1;
         if (stall_active) begin
            stall_seen++;
            check("stall_read_held", avm_read_n, 1'b0);
            if (exp_addr.size() == 0) fail("stall_addr_unexpected", avm_address);
            else check("stall_addr_held", avm_address, exp_addr[0]);
         end
         if (!avm_read_n && !avm_waitrequest) begin
            if (exp_addr.size() == 0) begin
               fail("read_unexpected", avm_address);
            end else begin
               ea = exp_addr.pop_front();
               check("read_addr", avm_address, ea);
            end
            lat   = $urandom_range(lat_max, lat_min);
            r.data = mem_word(avm_address);
            r.due  = cyc + lat;
            pipe.push_back(r);
            if (xfer_acc == 0) first_acc = cyc;
            last_acc = cyc;
            xfer_acc++;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output monitor: pops the scoreboard whenever a word is accepted
   // ---------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (hold_prev && out_valid) check("out_data_stable", out_data, prev_data);
         if (out_valid && out_ready) begin
            if (exp_data.size() == 0) fail("word_unexpected", out_data);
            else check("out_data", out_data, exp_data.pop_front());
         end
         hold_prev = out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic start_xfer(input logic [24:0] b, input logic [23:0] n);
      logic [24:0] a;
      for (int i = 0; i < int'(n); i++) begin
         a = b + 25'(i);
         exp_addr.push_back(a);
         exp_data.push_back(mem_word(a));
      end
      xfer_acc = 0;
      any_read = 1'b0;
      @(posedge clk);
      #1;
      start      = 1'b1;
      base_addr  = b;
      word_count = n;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, output int waited);
      bit seen;
      int d0;
      seen   = 1'b0;
      d0     = done_cnt;
      waited = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         #1;
         if (done) begin
            seen   = 1'b1;
            waited = i;
            check({name, "_busy_at_done"}, busy, 1'b0);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_done_timeout: got no done within %0d cycles, required a done pulse", name, budget);
      end else begin
         @(negedge clk);
         #1;
         check({name, "_done_width"}, done, 1'b0);
         check({name, "_busy_after"}, busy, 1'b0);
         check({name, "_done_pulses"}, done_cnt - d0, 1);
      end
      check({name, "_words_left"}, exp_data.size(), 0);
      check({name, "_reads_left"}, exp_addr.size(), 0);
   endtask

   task automatic check_reset_values(input string name);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_done"}, done, 1'b0);
      check({name, "_read_n"}, avm_read_n, 1'b1);
      check({name, "_chipselect"}, avm_chipselect, 1'b0);
      check({name, "_address"}, avm_address, 0);
      check({name, "_out_valid"}, out_valid, 1'b0);
   endtask

   // Hard bound on total run time.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------
   initial begin
      int waited;
      int rdv_seen;
      bit valid_seen;
      bit reached;
      logic [24:0] rb;
      logic [23:0] rn;

      reset_reset = 1'b1;
      start       = 1'b0;
      base_addr   = '0;
      word_count  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_values("reset");
      check("const_byteenable_n", avm_byteenable_n, 2'b00);
      check("const_write_n", avm_write_n, 1'b1);
      check("const_writedata", avm_writedata, 0);
      @(posedge clk);
      #1;
      reset_reset = 1'b0;

      // 1: four words, fixed latency 3, consumer always ready
      lat_min = 3; lat_max = 3; rdy_mode = 0; wait_pct = 0;
      start_xfer(25'h100, 24'd4);
      wait_done("t1", 200, waited);
      check("t1_reads", xfer_acc, 4);
      check("t1_back_to_back", last_acc - first_acc, 3);

      // 2: consumer stalled, credit limit caps reads at FIFO_DEPTH
      lat_min = 1; lat_max = 4; rdy_mode = 1;
      start_xfer(25'h4000, 24'd40);
      repeat (60) @(negedge clk);
      #1;
      check("t2_reads_capped", xfer_acc, DEPTH);
      check("t2_read_idle", avm_read_n, 1'b1);
      check("t2_fifo_full_valid", out_valid, 1'b1);
      rdy_mode = 0;
      wait_done("t2", 1000, waited);
      check("t2_reads_total", xfer_acc, 40);

      // 3: waitrequest held for five cycles on the second read
      lat_min = 2; lat_max = 2;
      stall_idx = 1; stall_left = 5; stall_seen = 0;
      start_xfer(25'h800, 24'd6);
      wait_done("t3", 300, waited);
      check("t3_stall_cycles", stall_seen, 5);
      check("t3_reads", xfer_acc, 6);
      stall_idx = -1;

      // 4: address wraps at the top of the 25-bit space
      lat_min = 1; lat_max = 3;
      start_xfer(25'h1FF_FFFF, 24'd2);
      wait_done("t4", 200, waited);
      check("t4_reads", xfer_acc, 2);

      // 5a: zero-length transfer
      start_xfer(25'h500, 24'd0);
      wait_done("t5a", 20, waited);
      check("t5a_done_latency", waited, 0);
      check("t5a_no_read", any_read, 1'b0);

      // 5b: start while busy is ignored
      start_xfer(25'h300, 24'd8);
      @(posedge clk);
      #1;
      start = 1'b1; base_addr = 25'h999; word_count = 24'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("t5b", 300, waited);
      repeat (5) @(negedge clk);
      #1;
      check("t5b_reads", xfer_acc, 8);

      // 6: reset with three reads outstanding, stale returns afterwards
      lat_min = 8; lat_max = 8;
      start_xfer(25'h600, 24'd10);
      reached = 1'b0;
      for (int i = 0; i < 50 && !reached; i++) begin
         @(negedge clk);
         #1;
         if (xfer_acc >= 3) begin
            force_wait = 1'b1;
            reached    = 1'b1;
         end
      end
      check("t6_three_issued", xfer_acc, 3);
      @(posedge clk);
      #1;
      reset_reset = 1'b1;
      exp_addr.delete();
      exp_data.delete();
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      check_reset_values("t6_in_reset");
      check("t6_pending_at_reset", pipe.size(), 3);
      @(posedge clk);
      #1;
      reset_reset = 1'b0;
      force_wait  = 1'b0;
      rdv_seen   = 0;
      valid_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (avm_readdatavalid) rdv_seen++;
         if (out_valid) valid_seen = 1'b1;
      end
      check("t6_stale_returns", rdv_seen, 3);
      check("t6_stale_not_pushed", valid_seen, 1'b0);
      lat_min = 2; lat_max = 2;
      start_xfer(25'h200, 24'd2);
      wait_done("t6", 200, waited);
      check("t6_reads", xfer_acc, 2);

      // Randomized transfers
      for (int k = 0; k < 8; k++) begin
         rb       = 25'($urandom);
         rn       = 24'($urandom_range(1, 50));
         lat_min  = $urandom_range(1, 3);
         lat_max  = lat_min + $urandom_range(0, 4);
         wait_pct = $urandom_range(0, 40);
         rdy_mode = 2;
         start_xfer(rb, rn);
         wait_done("rand", 3000, waited);
         check("rand_reads", xfer_acc, int'(rn));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
